lfsr_checker: RTL and testbench



---
 rtl/lfsr_pkg.sv | 41 ++++
 rtl/lfsr_step.sv | 31 +++
 rtl/lfsr_checker.sv | 174 +++++++++++++++++
 tb/tb_lfsr_checker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit data / 10-bit address LFSR pair:
// Galois tap masks, seeds, next-state functions and the checker FSM encoding.
`timescale 1ns/1ps
package lfsr_pkg;

  localparam int unsigned D_W = 32;
  localparam int unsigned A_W = 10;

  localparam logic [D_W-1:0] D_SEED = 32'hFFFF_FFFF;
  localparam logic [A_W-1:0] A_SEED = 10'h3FF;

  // Bit i set: next[i] also takes the feedback bit (msb of current state).
  // Bit 0 is implied (it receives the msb directly).
  localparam logic [D_W-1:0] D_TAPS = 32'h0040_0007;
  localparam logic [A_W-1:0] A_TAPS = 10'h009;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  function automatic logic [D_W-1:0] d32_next(input logic [D_W-1:0] s);
    logic [D_W-1:0] n;
    n[0] = s[D_W-1];
    for (int i = 1; i < D_W; i++) begin
      n[i] = s[i-1] ^ (D_TAPS[i] & s[D_W-1]);
    end
    return n;
  endfunction

  function automatic logic [A_W-1:0] a10_next(input logic [A_W-1:0] s);
    logic [A_W-1:0] n;
    n[0] = s[A_W-1];
    for (int i = 1; i < A_W; i++) begin
      n[i] = s[i-1] ^ (A_TAPS[i] & s[A_W-1]);
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational one-step advance of the data/address LFSR pair.
`timescale 1ns/1ps
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [31:0] d_in,
  input  logic [9:0]  a_in,
  output logic [31:0] d_out,
  output logic [9:0]  a_out
);

  assign d_out[0] = d_in[31];
  assign a_out[0] = a_in[9];

  for (genvar gi = 1; gi < 32; gi++) begin : g_d
    if (D_TAPS[gi]) begin : g_tap
      assign d_out[gi] = d_in[gi-1] ^ d_in[31];
    end else begin : g_shift
      assign d_out[gi] = d_in[gi-1];
    end
  end

  for (genvar gi = 1; gi < 10; gi++) begin : g_a
    if (A_TAPS[gi]) begin : g_tap
      assign a_out[gi] = a_in[gi-1] ^ a_in[9];
    end else begin : g_shift
      assign a_out[gi] = a_in[gi-1];
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the LFSR data/address beat stream:
// hunts for a seed, verifies LOCK_COUNT predictions, then counts deviations.
`timescale 1ns/1ps
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 8,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic [9:0]       in_addr,
  input  logic             chk_addr,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_seen,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      first_err_data,
  output logic [31:0]      first_err_rx
);

  chk_state_e       state_q, state_d;
  logic [31:0]      exp_d_q, exp_d_d;
  logic [9:0]       exp_a_q, exp_a_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [7:0]       miss_cnt_q, miss_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_seen_q, err_seen_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [31:0]      first_err_data_q, first_err_data_d;
  logic [31:0]      first_err_rx_q, first_err_rx_d;

  logic [31:0] step_d, seed_d;
  logic [9:0]  step_a, seed_a;
  logic        beat_match;
  logic        log_err;
  logic [4:0]  match_inc;
  logic [8:0]  miss_inc;

  // Prediction from our own expectation, and reseed from the received beat.
  lfsr_step u_step_exp (
    .d_in  (exp_d_q),
    .a_in  (exp_a_q),
    .d_out (step_d),
    .a_out (step_a)
  );

  lfsr_step u_step_rx (
    .d_in  (in_data),
    .a_in  (in_addr),
    .d_out (seed_d),
    .a_out (seed_a)
  );

  assign beat_match = (in_data == exp_d_q) && (!chk_addr || (in_addr == exp_a_q));
  assign match_inc  = {1'b0, match_cnt_q} + 5'd1;
  assign miss_inc   = {1'b0, miss_cnt_q} + 9'd1;

  always_comb begin
    state_d          = state_q;
    exp_d_d          = exp_d_q;
    exp_a_d          = exp_a_q;
    match_cnt_d      = match_cnt_q;
    miss_cnt_d       = miss_cnt_q;
    err_pulse_d      = 1'b0;
    err_seen_d       = err_seen_q;
    err_count_d      = err_count_q;
    first_err_data_d = first_err_data_q;
    first_err_rx_d   = first_err_rx_q;
    log_err          = 1'b0;

    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          // All-zero is the LFSR lock-up word and can never be a valid seed.
          if (in_data != 32'd0) begin
            exp_d_d     = seed_d;
            exp_a_d     = seed_a;
            match_cnt_d = 4'd0;
            state_d     = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (beat_match) begin
            match_cnt_d = match_inc[3:0];
            exp_d_d     = step_d;
            exp_a_d     = step_a;
            if (match_inc == 5'(LOCK_COUNT)) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = 8'd0;
            end
          end else begin
            exp_d_d     = seed_d;
            exp_a_d     = seed_a;
            match_cnt_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          exp_d_d = step_d;
          exp_a_d = step_a;
          if (beat_match) begin
            miss_cnt_d = 8'd0;
          end else begin
            err_pulse_d = 1'b1;
            log_err     = 1'b1;
            miss_cnt_d  = miss_inc[7:0];
            if (miss_inc == 9'(LOSS_COUNT)) begin
              state_d    = ST_HUNT;
              miss_cnt_d = 8'd0;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (log_err) begin
      if (err_count_q != {ERR_W{1'b1}}) begin
        err_count_d = err_count_q + 1'b1;
      end
      if (!err_seen_q) begin
        first_err_data_d = exp_d_q;
        first_err_rx_d   = in_data;
      end
      err_seen_d = 1'b1;
    end

    // Clear overrides error bookkeeping only; lock tracking carries on.
    if (clr) begin
      err_count_d      = '0;
      err_seen_d       = 1'b0;
      first_err_data_d = 32'd0;
      first_err_rx_d   = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_HUNT;
      exp_d_q          <= 32'd0;
      exp_a_q          <= 10'd0;
      match_cnt_q      <= 4'd0;
      miss_cnt_q       <= 8'd0;
      err_pulse_q      <= 1'b0;
      err_seen_q       <= 1'b0;
      err_count_q      <= '0;
      first_err_data_q <= 32'd0;
      first_err_rx_q   <= 32'd0;
    end else begin
      state_q          <= state_d;
      exp_d_q          <= exp_d_d;
      exp_a_q          <= exp_a_d;
      match_cnt_q      <= match_cnt_d;
      miss_cnt_q       <= miss_cnt_d;
      err_pulse_q      <= err_pulse_d;
      err_seen_q       <= err_seen_d;
      err_count_q      <= err_count_d;
      first_err_data_q <= first_err_data_d;
      first_err_rx_q   <= first_err_rx_d;
    end
  end

  assign locked         = (state_q == ST_LOCKED);
  assign err_pulse      = err_pulse_q;
  assign err_seen       = err_seen_q;
  assign err_count      = err_count_q;
  assign first_err_data = first_err_data_q;
  assign first_err_rx   = first_err_rx_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised bench for lfsr_checker against a behavioural stream model.
`timescale 1ns/1ps
module tb_lfsr_checker;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 8;
  localparam int EW     = 4;
  localparam int SAT    = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [31:0]   in_data;
  logic [9:0]    in_addr;
  logic          chk_addr;
  logic          clr;
  logic          locked;
  logic          err_pulse;
  logic          err_seen;
  logic [EW-1:0] err_count;
  logic [31:0]   first_err_data;
  logic [31:0]   first_err_rx;

  lfsr_checker #(
    .LOCK_COUNT (LOCK_N),
    .LOSS_COUNT (LOSS_N),
    .ERR_W      (EW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_addr        (in_addr),
    .chk_addr       (chk_addr),
    .clr            (clr),
    .locked         (locked),
    .err_pulse      (err_pulse),
    .err_seen       (err_seen),
    .err_count      (err_count),
    .first_err_data (first_err_data),
    .first_err_rx   (first_err_rx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, want, $time);
  endtask

  // Generator side: the polynomial as a feedback mask applied after a shift.
  function automatic logic [31:0] nx32(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0);
  endfunction
  function automatic logic [9:0] nx10(input logic [9:0] s);
    return {s[8:0], 1'b0} ^ (s[9] ? 10'h009 : 10'h0);
  endfunction

  logic [31:0] gen_d;
  logic [9:0]  gen_a;

  // Reference model: mode 0=searching, 1=confirming, 2=locked.
  int          m_mode, m_hits, m_misses, m_cnt;
  logic [31:0] m_exp_d, m_fd, m_frx;
  logic [9:0]  m_exp_a;
  bit          m_pulse, m_seen;

  task automatic model_reset();
    m_mode = 0; m_hits = 0; m_misses = 0; m_cnt = 0;
    m_exp_d = 0; m_exp_a = 0; m_fd = 0; m_frx = 0;
    m_pulse = 0; m_seen = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] d, input logic [9:0] a,
                            input bit ca, input bit cl, input bit r);
    bit ok;
    if (r) begin
      model_reset();
      return;
    end
    m_pulse = 0;
    ok = (d == m_exp_d) && (!ca || a == m_exp_a);
    if (v) begin
      if (m_mode == 0) begin
        if (d != 0) begin
          m_exp_d = nx32(d); m_exp_a = nx10(a); m_hits = 0; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (ok) begin
          m_hits++;
          m_exp_d = nx32(m_exp_d); m_exp_a = nx10(m_exp_a);
          if (m_hits == LOCK_N) begin m_mode = 2; m_misses = 0; end
        end else begin
          m_exp_d = nx32(d); m_exp_a = nx10(a); m_hits = 0;
        end
      end else begin
        if (ok) m_misses = 0;
        else begin
          m_pulse = 1;
          if (m_cnt < SAT) m_cnt++;
          if (!m_seen) begin m_fd = m_exp_d; m_frx = d; end
          m_seen = 1;
          m_misses++;
          if (m_misses == LOSS_N) begin m_mode = 0; m_misses = 0; end
        end
        m_exp_d = nx32(m_exp_d); m_exp_a = nx10(m_exp_a);
      end
    end
    if (cl) begin
      m_cnt = 0; m_seen = 0; m_fd = 0; m_frx = 0;
    end
  endtask

  task automatic compare_all();
    check("locked",    32'(locked),    32'(m_mode == 2));
    check("err_pulse", 32'(err_pulse), 32'(m_pulse));
    check("err_seen",  32'(err_seen),  32'(m_seen));
    check("err_count", 32'(err_count), 32'(m_cnt));
    check("first_err_data", first_err_data, m_fd);
    check("first_err_rx",   first_err_rx,   m_frx);
  endtask

  // Drive one cycle's inputs, clock it, then compare a little after the edge.
  task automatic cycle(input bit v, input logic [31:0] d, input logic [9:0] a,
                       input bit ca, input bit cl, input bit r);
    in_valid = v; in_data = d; in_addr = a; chk_addr = ca; clr = cl; rst = r;
    @(posedge clk);
    model_step(v, d, a, ca, cl, r);
    #1;
    compare_all();
  endtask

  task automatic gen_adv();
    gen_d = nx32(gen_d);
    gen_a = nx10(gen_a);
  endtask

  task automatic clean_beat(input bit ca);
    cycle(1, gen_d, gen_a, ca, 0, 0);
    gen_adv();
  endtask

  task automatic bad_beat(input bit cl);
    logic [31:0] flip;
    flip = $urandom() | 32'h1;
    cycle(1, gen_d ^ flip, gen_a, 1, cl, 0);
    gen_adv();
  endtask

  logic [31:0] saved_d;

  initial begin
    in_valid = 0; in_data = 0; in_addr = 0; chk_addr = 1; clr = 0; rst = 1;
    model_reset();
    gen_d = 32'hFFFF_FFFF; gen_a = 10'h3FF;

    cycle(0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 0, 1);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_count",  32'(err_count), 32'd0);

    // Zero words in hunt are ignored, then acquisition from the seed.
    repeat (6) cycle(1, 32'd0, 10'd0, 1, 0, 0);
    check("zero_no_lock", 32'(locked), 32'd0);
    check("second_beat", nx32(32'hFFFF_FFFF), 32'hFFBF_FFF9);
    for (int i = 1; i <= 5; i++) begin
      clean_beat(1);
      if (i == 4) check("not_locked_beat4", 32'(locked), 32'd0);
    end
    check("locked_beat5", 32'(locked), 32'd1);
    repeat (1995) clean_beat(1);
    check("clean_count", 32'(err_count), 32'd0);

    // Single corrupted data beat.
    saved_d = gen_d;
    cycle(1, gen_d ^ 32'h1, gen_a, 1, 0, 0);
    gen_adv();
    check("single_pulse", 32'(err_pulse), 32'd1);
    check("single_count", 32'(err_count), 32'd1);
    check("single_fd",  first_err_data, saved_d);
    check("single_frx", first_err_rx,   saved_d ^ 32'h1);
    clean_beat(1);
    check("single_pulse_off", 32'(err_pulse), 32'd0);
    check("single_still_locked", 32'(locked), 32'd1);
    repeat (20) clean_beat(1);

    // Burst loss then relock.
    cycle(0, 0, 0, 1, 1, 0);
    repeat (LOSS_N) bad_beat(0);
    check("burst_count", 32'(err_count), 32'(LOSS_N));
    check("burst_unlock", 32'(locked), 32'd0);
    repeat (5) clean_beat(1);
    check("burst_relock", 32'(locked), 32'd1);

    // Address-only corruption with and without address compare.
    cycle(0, 0, 0, 1, 1, 0);
    repeat (10) begin
      cycle(1, gen_d, gen_a ^ 10'(($urandom() | 1)), 0, 0, 0);
      gen_adv();
    end
    check("addr_ignored", 32'(err_count), 32'd0);
    repeat (3) begin
      cycle(1, gen_d, gen_a ^ 10'(($urandom() | 1)), 1, 0, 0);
      gen_adv();
    end
    check("addr_counted", 32'(err_count), 32'd3);
    check("addr_locked", 32'(locked), 32'd1);

    // Random gaps with occasional corruption.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) < 3) cycle(0, $urandom(), 10'($urandom()), 1, 0, 0);
      else if ($urandom_range(99) < 2) bad_beat(0);
      else clean_beat(1);
    end

    // Saturation: 20 errors across relocks.
    repeat (10) clean_beat(1);
    cycle(0, 0, 0, 1, 1, 0);
    repeat (LOSS_N) bad_beat(0);
    repeat (5) clean_beat(1);
    repeat (LOSS_N) bad_beat(0);
    repeat (5) clean_beat(1);
    repeat (4) bad_beat(0);
    check("sat_count", 32'(err_count), 32'(SAT));
    bad_beat(1);
    check("clr_wins_count", 32'(err_count), 32'd0);
    check("clr_wins_seen", 32'(err_seen), 32'd0);
    check("clr_keeps_lock", 32'(locked), 32'd1);

    // Reset mid-lock, then reacquire.
    bad_beat(0);
    clean_beat(1);
    cycle(1, gen_d, gen_a, 1, 0, 1);
    gen_adv();
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_seen", 32'(err_seen), 32'd0);
    check("rst_fd", first_err_data, 32'd0);
    repeat (5) clean_beat(1);
    check("rst_relock", 32'(locked), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
